public_key_walker: RTL and testbench
====================================

Name: public_key_walker

Overview:
Initiator/sequencer for the secp256k1 point adder (P → P+G). Given a start point and a count, it emits P, P+G, P+2G, … on a valid/ready output stream. It drives the adder's start/operand interface and collects results. The next addition overlaps with downstream back-pressure; a one-deep hold buffer decouples the two.

Parameters:
COUNT_WIDTH, 32, width of rx_count, tx_index and the internal remaining-counter

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high; returns block to IDLE
rx_start  in  1  start request, sampled only in IDLE
rx_x  in  256  start point x, sampled with rx_start
rx_y  in  256  start point y, sampled with rx_start
rx_count  in  COUNT_WIDTH  number of points to emit, including the start point
tx_busy  out  1  high whenever state != IDLE
tx_valid  out  1  output point valid
tx_ready  in  1  downstream accept; transfer = tx_valid && tx_ready
tx_x  out  256  output point x
tx_y  out  256  output point y
tx_index  out  COUNT_WIDTH  k for output point P+kG
tx_error  out  1  sticky; set when an addition would hit x == G_x; cleared by the next accepted rx_start or by reset
add_reset  out  1  start pulse to adder; combinationally = reset OR (state == KICK)
add_x  out  256  adder operand x (work_x register); held stable for the whole addition
add_y  out  256  adder operand y (work_y register)
add_done  in  1  adder done level; cleared by adder one cycle after add_reset
add_result_x  in  256  adder result x, valid while add_done
add_result_y  in  256  adder result y

Behaviour:
- Reset values:
  - tx_valid=0, tx_busy=0, tx_error=0, tx_index=0; state=IDLE.
  - tx_x/tx_y/work regs are don't-care.
  - add_reset is high during reset, so the adder is reset too.
- States: IDLE, KICK, WAIT, HOLD, DRAIN.
- IDLE:
  - rx_start with rx_count==0: ignored entirely, no output, tx_error unchanged.
  - rx_start with rx_count!=0:
    - tx_x/tx_y and work_x/work_y ← rx_x/rx_y; tx_index←0; tx_valid←1 (visible the cycle after rx_start); remaining←rx_count−1; tx_error←0.
    - Next state: remaining==0 → DRAIN, else → KICK.
- KICK (exactly 1 cycle):
  - If work_x == G_x: do not pulse (P+G undefined/doubling case); tx_error←1; → DRAIN.
  - Otherwise add_reset=1; → WAIT.
- WAIT:
  - add_done is ignored until the cycle after KICK; WAIT is entered after KICK, so this holds automatically.
  - On add_done: work_x/work_y ← add_result_x/add_result_y.
  - Output slot free (tx_valid==0, or transfer this cycle):
    - tx_x/tx_y ← result; tx_valid←1; tx_index←tx_index+1; remaining←remaining−1.
    - Next state: remaining−1==0 → DRAIN, else → KICK.
  - Output slot not free → HOLD.
- HOLD: wait for transfer. In that cycle load the output from work_x/work_y and update tx_index/remaining as in WAIT; same next-state rule.
- DRAIN: wait for transfer of the last point (or tx_valid==0), then tx_valid←0 → IDLE.
- Throughput: one addition in flight at most; the adder restarts the cycle after a result is loaded to the output. Back-pressure never loses or duplicates a point.
- tx_x/tx_y/tx_index are stable while tx_valid && !tx_ready.
- rx_start while busy: ignored.
- Reset mid-operation: any state → IDLE next edge. An in-flight output is dropped (tx_valid=0) and the adder is reset.
- tx_index wrap: none. rx_count ≤ 2^COUNT_WIDTH−1 bounds it.

Decomposition:
- Shared package secp256k1_pkg: G_X, G_Y, P constants (256-bit) and the state encoding typedef. The existing adder migrates to the same constants.
- No sub-module; the adder is instantiated alongside by the parent, not inside this block.

Test Plan:
- rx=2G (x=C6047F94…709EE5, y=1AE168FE…50CFE52A), count=2, tx_ready=1 → idx0=2G; idx1 x=F9308A01…BCE036F9, y=388F7B0F…84B8E672 (3G); tx_busy falls after the second transfer.
- Same stimulus, tx_ready held 0 for 2000 cycles after idx0 → exactly one add_reset pulse; block sits in HOLD; releasing ready yields idx0 then idx1, outputs stable throughout stall.
- rx=G, count=3 → idx0=G emitted; no add_reset pulse; tx_error=1; no further points; IDLE after transfer; next rx_start clears tx_error.
- count=0 with rx_start → tx_valid never asserts, tx_busy stays 0; count=1 → single point, zero add_reset pulses.
- reset asserted in WAIT → next cycle tx_valid=0, tx_busy=0, add_reset high during reset; fresh start with rx=2G count=2 reproduces scenario 1.
- rx_start pulsed while busy → ignored; emitted sequence and tx_index (0,1,2,…) unchanged; random tx_ready over count=8 from 2G matches the software model.

Source files
------------

// File: rtl/secp256k1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : secp256k1_pkg
//  Purpose  : secp256k1 curve constants (generator G and field prime P) and
//             the state encoding used by the public-key walker.
//  Revision : 1.0 - initial release
// ============================================================================
package secp256k1_pkg;

  localparam logic [255:0] G_X =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] G_Y =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } walker_state_t;

endpackage
`default_nettype wire

// File: rtl/public_key_walker.sv
`default_nettype none
// ============================================================================
//  Module   : public_key_walker
//  Purpose  : Sequences an external P -> P+G adder to stream P, P+G, P+2G, ...
//             on a valid/ready port. A one-deep hold (work regs) lets the next
//             addition finish while the output is back-pressured.
//  Revision : 1.0 - initial release
// ============================================================================
module public_key_walker
  import secp256k1_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_start,
  input  logic [255:0]           rx_x,
  input  logic [255:0]           rx_y,
  input  logic [COUNT_WIDTH-1:0] rx_count,
  output logic                   tx_busy,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [255:0]           tx_x,
  output logic [255:0]           tx_y,
  output logic [COUNT_WIDTH-1:0] tx_index,
  output logic                   tx_error,
  output logic                   add_reset,
  output logic [255:0]           add_x,
  output logic [255:0]           add_y,
  input  logic                   add_done,
  input  logic [255:0]           add_result_x,
  input  logic [255:0]           add_result_y
);

  walker_state_t          r_state;
  walker_state_t          w_next_state;
  logic [255:0]           r_work_x;
  logic [255:0]           r_work_y;
  logic [255:0]           r_tx_x;
  logic [255:0]           r_tx_y;
  logic [COUNT_WIDTH-1:0] r_tx_index;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic                   r_tx_valid;
  logic                   r_tx_error;

  logic w_start_ok;
  logic w_slot_free;
  logic w_xfer;
  logic w_at_g;
  logic w_last;

  assign w_start_ok  = rx_start && (rx_count != '0);
  assign w_xfer      = r_tx_valid && tx_ready;
  assign w_slot_free = !r_tx_valid || tx_ready;
  // Adding G to a point with x == G_x is the doubling / infinity case the
  // adder cannot handle, so the walk stops there.
  assign w_at_g      = (r_work_x == G_X);
  // The point about to be loaded is the final one.
  assign w_last      = (r_remaining == COUNT_WIDTH'(1));

  assign tx_valid = r_tx_valid;
  assign tx_x     = r_tx_x;
  assign tx_y     = r_tx_y;
  assign tx_index = r_tx_index;
  assign tx_error = r_tx_error;
  assign add_x    = r_work_x;
  assign add_y    = r_work_y;

  // State register: reset forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next_state = (rx_count == COUNT_WIDTH'(1)) ? ST_DRAIN : ST_KICK;
        end
      end
      ST_KICK: begin
        w_next_state = w_at_g ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (add_done) begin
          if (w_slot_free) begin
            w_next_state = w_last ? ST_DRAIN : ST_KICK;
          end else begin
            w_next_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_slot_free) begin
          w_next_state = w_last ? ST_DRAIN : ST_KICK;
        end
      end
      ST_DRAIN: begin
        if (w_slot_free) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: adder start pulse and busy flag.
  always_comb begin
    add_reset = reset;
    tx_busy   = (r_state != ST_IDLE);
    if ((r_state == ST_KICK) && !w_at_g) begin
      add_reset = 1'b1;
    end
  end

  // Datapath: capture start point, adder results and the output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_valid <= 1'b0;
      r_tx_error <= 1'b0;
      r_tx_index <= '0;
    end else begin
      // A transfer empties the slot unless a new point is loaded below.
      if (w_xfer) begin
        r_tx_valid <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_work_x    <= rx_x;
            r_work_y    <= rx_y;
            r_tx_x      <= rx_x;
            r_tx_y      <= rx_y;
            r_tx_index  <= '0;
            r_tx_valid  <= 1'b1;
            r_remaining <= rx_count - COUNT_WIDTH'(1);
            r_tx_error  <= 1'b0;
          end
        end
        ST_KICK: begin
          if (w_at_g) begin
            r_tx_error <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (add_done) begin
            r_work_x <= add_result_x;
            r_work_y <= add_result_y;
            if (w_slot_free) begin
              r_tx_x      <= add_result_x;
              r_tx_y      <= add_result_y;
              r_tx_valid  <= 1'b1;
              r_tx_index  <= r_tx_index + COUNT_WIDTH'(1);
              r_remaining <= r_remaining - COUNT_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_slot_free) begin
            r_tx_x      <= r_work_x;
            r_tx_y      <= r_work_y;
            r_tx_valid  <= 1'b1;
            r_tx_index  <= r_tx_index + COUNT_WIDTH'(1);
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_public_key_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_public_key_walker
//  Purpose  : Self-checking bench for public_key_walker with a behavioural
//             secp256k1 adder and an arithmetic reference for the k*G walk.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_public_key_walker;
  import secp256k1_pkg::*;

  localparam int CW = 32;
  localparam logic [255:0] C_2GX =
    256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
  localparam logic [255:0] C_2GY =
    256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
  localparam logic [255:0] C_3GX =
    256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
  localparam logic [255:0] C_3GY =
    256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_start = 1'b0;
  logic [255:0]  rx_x = '0;
  logic [255:0]  rx_y = '0;
  logic [CW-1:0] rx_count = '0;
  logic          tx_busy, tx_valid, tx_error, add_reset;
  logic          tx_ready = 1'b0;
  logic [255:0]  tx_x, tx_y, add_x, add_y;
  logic [CW-1:0] tx_index;
  logic          add_done = 1'b0;
  logic [255:0]  add_result_x = '0;
  logic [255:0]  add_result_y = '0;

  public_key_walker #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .rx_start(rx_start), .rx_x(rx_x), .rx_y(rx_y),
    .rx_count(rx_count), .tx_busy(tx_busy), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_x(tx_x), .tx_y(tx_y), .tx_index(tx_index),
    .tx_error(tx_error), .add_reset(add_reset), .add_x(add_x), .add_y(add_y),
    .add_done(add_done), .add_result_x(add_result_x),
    .add_result_y(add_result_y)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- field / curve arithmetic ----------------
  function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, P} - {1'b0, b};
    return t[255:0];
  endfunction

  function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    logic [511:0] m;
    t = {256'd0, a} * {256'd0, b};
    m = t % {256'd0, P};
    return m[255:0];
  endfunction

  function automatic logic [255:0] invm(input logic [255:0] a);
    logic [255:0] r, base, e;
    r = 256'd1;
    base = a;
    e = P - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulm(r, base);
      base = mulm(base, base);
    end
    return r;
  endfunction

  function automatic void ecadd(input logic [255:0] x1, input logic [255:0] y1,
                                input logic [255:0] x2, input logic [255:0] y2,
                                output logic [255:0] x3, output logic [255:0] y3);
    logic [255:0] l;
    l  = mulm(subm(y2, y1), invm(subm(x2, x1)));
    x3 = subm(subm(mulm(l, l), x1), x2);
    y3 = subm(mulm(l, subm(x1, x3)), y1);
  endfunction

  // ---------------- behavioural adder ----------------
  int          m_lat;
  bit          m_busy = 1'b0;
  logic [255:0] m_x3, m_y3;
  always @(posedge clk) begin
    if (reset) begin
      add_done <= 1'b0;
      m_busy   <= 1'b0;
    end else if (add_reset) begin
      add_done <= 1'b0;
      m_busy   <= 1'b1;
      m_lat    <= int'($urandom_range(6, 2));
    end else if (m_busy) begin
      if (m_lat == 0) begin
        ecadd(add_x, add_y, G_X, G_Y, m_x3, m_y3);
        add_result_x <= m_x3;
        add_result_y <= m_y3;
        add_done     <= 1'b1;
        m_busy       <= 1'b0;
      end else begin
        m_lat <= m_lat - 1;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [255:0]  got_x[$], got_y[$];
  logic [CW-1:0] got_idx[$];
  int            pulses = 0;
  bit            saw_busy = 1'b0;
  bit            hold_prev = 1'b0;
  logic [255:0]  prev_x, prev_y;
  logic [CW-1:0] prev_idx;
  always @(negedge clk) begin
    if (!reset) begin
      if (add_reset) pulses++;
      if (tx_busy) saw_busy = 1'b1;
      if (hold_prev) begin
        check("stall_valid", {255'd0, tx_valid}, 256'd1);
        check("stall_x", tx_x, prev_x);
        check("stall_y", tx_y, prev_y);
        check("stall_idx", {224'd0, tx_index}, {224'd0, prev_idx});
      end
      if (tx_valid && tx_ready) begin
        got_x.push_back(tx_x);
        got_y.push_back(tx_y);
        got_idx.push_back(tx_index);
      end
      hold_prev = tx_valid && !tx_ready;
      prev_x = tx_x;
      prev_y = tx_y;
      prev_idx = tx_index;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- reference walk ----------------
  logic [255:0] exp_x[$], exp_y[$];
  int           exp_pulses;
  bit           model_err = 1'b0;

  task automatic build_expected(input logic [255:0] x, input logic [255:0] y, input int cnt);
    logic [255:0] cx, cy, nx, ny;
    exp_x.delete();
    exp_y.delete();
    exp_pulses = 0;
    if (cnt == 0) return;
    model_err = 1'b0;
    cx = x;
    cy = y;
    exp_x.push_back(cx);
    exp_y.push_back(cy);
    for (int k = 1; k < cnt; k++) begin
      if (cx == G_X) begin
        model_err = 1'b1;
        break;
      end
      ecadd(cx, cy, G_X, G_Y, nx, ny);
      exp_pulses++;
      cx = nx;
      cy = ny;
      exp_x.push_back(cx);
      exp_y.push_back(cy);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [255:0] x, input logic [255:0] y, input int cnt);
    got_x.delete();
    got_y.delete();
    got_idx.delete();
    pulses = 0;
    saw_busy = 1'b0;
    rx_x = x;
    rx_y = y;
    rx_count = CW'(cnt);
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
  endtask

  task automatic drain(input int rpct, input bit inject);
    bit finished = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (!tx_busy && !tx_valid) begin
        finished = 1'b1;
        break;
      end
      tx_ready = ($urandom_range(99) < rpct);
      if (inject && tx_busy && ($urandom_range(3) == 0)) begin
        rx_start = 1'b1;
        rx_x = {8{$urandom}};
        rx_y = {8{$urandom}};
        rx_count = 32'd5;
      end
      @(posedge clk); #1;
      rx_start = 1'b0;
    end
    tx_ready = 1'b0;
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got busy=%0d valid=%0d required idle", tx_busy, tx_valid);
    end
  endtask

  task automatic check_against_model(input string tag, input int exp_pts);
    check({tag, "_npts"}, 256'(got_x.size()), 256'(exp_pts));
    check({tag, "_pulses"}, 256'(pulses), 256'(exp_pulses));
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
      check($sformatf("%s_x%0d", tag, i), got_x[i], exp_x[i]);
      check($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
      check($sformatf("%s_idx%0d", tag, i), {224'd0, got_idx[i]}, 256'(i));
    end
  endtask

  task automatic check_2g_3g(input string tag);
    check({tag, "_npts"}, 256'(got_x.size()), 256'd2);
    if (got_x.size() == 2) begin
      check({tag, "_x0"}, got_x[0], C_2GX);
      check({tag, "_y0"}, got_y[0], C_2GY);
      check({tag, "_x1"}, got_x[1], C_3GX);
      check({tag, "_y1"}, got_y[1], C_3GY);
      check({tag, "_idx1"}, {224'd0, got_idx[1]}, 256'd1);
    end
    check({tag, "_pulses"}, 256'(pulses), 256'd1);
    check({tag, "_busy"}, {255'd0, tx_busy}, 256'd0);
  endtask

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    int           cnt;
    int           rpct;
    bit           inject;
    int           exp_pts;
    bit           exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{C_2GX, C_2GY,        2, 100, 1'b0, 2, 1'b0};
    tbl[1] = '{G_X,   G_Y,          3, 100, 1'b0, 1, 1'b1};
    tbl[2] = '{C_2GX, C_2GY,        0, 100, 1'b0, 0, 1'b1};
    tbl[3] = '{C_2GX, C_2GY,        1, 100, 1'b0, 1, 1'b0};
    tbl[4] = '{C_2GX, C_2GY,        8,  50, 1'b1, 8, 1'b0};
    tbl[5] = '{C_3GX, C_3GY,        5,  30, 1'b1, 5, 1'b0};
    tbl[6] = '{G_X,   P - G_Y,      2,  70, 1'b0, 1, 1'b1};
    tbl[7] = '{G_X,   G_Y,          1, 100, 1'b0, 1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_add_reset", {255'd0, add_reset}, 256'd1);
    check("rst_valid", {255'd0, tx_valid}, 256'd0);
    check("rst_busy", {255'd0, tx_busy}, 256'd0);
    check("rst_error", {255'd0, tx_error}, 256'd0);
    check("rst_index", {224'd0, tx_index}, 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 2G, count 2, always ready
    tx_ready = 1'b1;
    do_start(C_2GX, C_2GY, 2);
    check("s1_valid_after_start", {255'd0, tx_valid}, 256'd1);
    check("s1_idx_after_start", {224'd0, tx_index}, 256'd0);
    drain(100, 1'b0);
    check_2g_3g("s1");

    // Long stall after the first point
    tx_ready = 1'b0;
    do_start(C_2GX, C_2GY, 2);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
    end
    check("stall_pulses", 256'(pulses), 256'd1);
    check("stall_hold_valid", {255'd0, tx_valid}, 256'd1);
    check("stall_hold_busy", {255'd0, tx_busy}, 256'd1);
    check("stall_hold_idx", {224'd0, tx_index}, 256'd0);
    check("stall_hold_x", tx_x, C_2GX);
    drain(100, 1'b0);
    check_2g_3g("stall");

    // Reset while the adder is running
    tx_ready = 1'b0;
    do_start(C_2GX, C_2GY, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_add_reset", {255'd0, add_reset}, 256'd1);
    @(posedge clk); #1;
    check("midrst_valid", {255'd0, tx_valid}, 256'd0);
    check("midrst_busy", {255'd0, tx_busy}, 256'd0);
    reset = 1'b0;
    model_err = 1'b0;
    @(posedge clk); #1;
    do_start(C_2GX, C_2GY, 2);
    drain(100, 1'b0);
    check_2g_3g("after_rst");

    // Table-driven runs against the reference walk
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      build_expected(tbl[r].x, tbl[r].y, tbl[r].cnt);
      do_start(tbl[r].x, tbl[r].y, tbl[r].cnt);
      drain(tbl[r].rpct, tbl[r].inject);
      check_against_model(tag, tbl[r].exp_pts);
      check({tag, "_error"}, {255'd0, tx_error}, {255'd0, tbl[r].exp_err});
      check({tag, "_model_error"}, {255'd0, tx_error}, {255'd0, model_err});
      if (tbl[r].cnt == 0) begin
        check({tag, "_busy_seen"}, {255'd0, saw_busy}, 256'd0);
      end
      repeat (2) @(posedge clk);
      #1;
    end

    // Random walks from random small multiples of G
    for (int t = 0; t < 3; t++) begin
      logic [255:0] sx, sy, nx, ny;
      int           mult, cnt;
      sx = G_X;
      sy = G_Y;
      mult = int'($urandom_range(4, 1));
      for (int m = 1; m < mult; m++) begin
        ecadd(sx, sy, G_X, G_Y, nx, ny);
        sx = nx;
        sy = ny;
      end
      cnt = int'($urandom_range(6, 2));
      if (mult == 1) cnt = 1;
      build_expected(sx, sy, cnt);
      do_start(sx, sy, cnt);
      drain(int'($urandom_range(90, 20)), 1'b1);
      check_against_model($sformatf("rnd%0d", t), exp_x.size());
      check($sformatf("rnd%0d_error", t), {255'd0, tx_error}, {255'd0, model_err});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
